// File: rtl/bf16_norm_round_if.sv
// Handshake bundle for the bf16 normalise/round stage: input beat from the adder,
// output beat carrying the packed bf16 result.
interface bf16_norm_round_if #(
  parameter int MANT_W = 12,
  parameter int EXP_W  = 10
);
  logic                    valid_i;
  logic                    ready_o;
  logic                    sign_i;
  logic signed [EXP_W-1:0] exp_i;
  logic [MANT_W-1:0]       mant_i;
  logic                    valid_o;
  logic                    ready_i;
  logic [15:0]             res_o;

  modport master (
    output valid_i, sign_i, exp_i, mant_i, ready_i,
    input  ready_o, valid_o, res_o
  );

  modport slave (
    input  valid_i, sign_i, exp_i, mant_i, ready_i,
    output ready_o, valid_o, res_o
  );
endinterface

// File: rtl/bf16_norm_round.sv
// Post-add normalise (stage 1) and round-to-nearest-even / pack (stage 2) for bf16.
// Includes the leading-zero counter it relies on.
module lzc #(
  parameter int W  = 11,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  a,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (a[i]) cnt = CW'(W - 1 - i);
    end
  end
endmodule

module bf16_norm_round #(
  parameter int MANT_W = 12,
  parameter int EXP_W  = 10
) (
  input logic              clk,
  input logic              reset,
  bf16_norm_round_if.slave bus
);
  localparam int CNT_W = 4;
  localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic signed [EXP_W:0]   EXP_MAX = (EXP_W + 1)'(255);
  localparam logic signed [EXP_W:0]   EXP_MIN = '0;

  // Round-to-nearest-even on the 7-bit fraction; bit 7 of the result is the carry-out.
  function automatic logic [7:0] round_frac(input logic [9:0] m);
    logic rnd;
    rnd = m[2] & (m[3] | m[1] | m[0]);
    return {1'b0, m[9:3]} + {7'b0, rnd};
  endfunction

  // Saturating pack: flush to signed zero on underflow, infinity on overflow.
  function automatic logic [15:0] sat_pack(input logic sign, input logic zero,
                                           input logic signed [EXP_W:0] e,
                                           input logic [6:0] frac);
    if (zero || e <= EXP_MIN) return {sign, 15'h0};
    else if (e >= EXP_MAX)    return {sign, 8'hFF, 7'h0};
    else                      return {sign, e[7:0], frac};
  endfunction

  logic                    s2_adv, s1_adv;
  logic [CNT_W-1:0]        lz_cnt;
  logic                    vld_p1_q, vld_p1_d;
  logic                    sign_p1_q, sign_p1_d;
  logic                    zero_p1_q, zero_p1_d;
  logic [9:0]              mant_p1_q, mant_p1_d;
  logic signed [EXP_W-1:0] exp_p1_q, exp_p1_d;
  logic                    vld_p2_q, vld_p2_d;
  logic [15:0]             res_p2_q, res_p2_d;
  logic [MANT_W-1:0]       mant_sh;
  logic [7:0]              frac_r;
  logic signed [EXP_W:0]   exp_r;

  lzc #(.W(11)) u_lzc (
    .a   (bus.mant_i[10:0]),
    .cnt (lz_cnt)
  );

  assign s2_adv      = !vld_p2_q || bus.ready_i;
  assign s1_adv      = !vld_p1_q || s2_adv;
  assign bus.ready_o = s1_adv;
  assign bus.valid_o = vld_p2_q;
  assign bus.res_o   = res_p2_q;

  // Stage p1: normalise so the hidden one lands on bit 10; only the fraction/G/S bits are kept.
  always_comb begin
    vld_p1_d  = vld_p1_q;
    sign_p1_d = sign_p1_q;
    zero_p1_d = zero_p1_q;
    mant_p1_d = mant_p1_q;
    exp_p1_d  = exp_p1_q;
    mant_sh   = '0;
    if (s1_adv) vld_p1_d = bus.valid_i;
    if (s1_adv && bus.valid_i) begin
      sign_p1_d = bus.sign_i;
      zero_p1_d = (bus.mant_i == '0);
      if (bus.mant_i[11]) begin
        mant_sh  = {1'b0, bus.mant_i[11:2], |bus.mant_i[1:0]};
        exp_p1_d = bus.exp_i + EXP_ONE;
      end else begin
        mant_sh  = bus.mant_i << lz_cnt;
        exp_p1_d = bus.exp_i - $signed({{(EXP_W - CNT_W){1'b0}}, lz_cnt});
      end
      mant_p1_d = mant_sh[9:0];
    end
  end

  // Stage p2: round, propagate fraction carry into the exponent, saturate and pack.
  always_comb begin
    frac_r   = round_frac(mant_p1_q);
    exp_r    = $signed({exp_p1_q[EXP_W-1], exp_p1_q}) + $signed({{EXP_W{1'b0}}, frac_r[7]});
    vld_p2_d = vld_p2_q;
    res_p2_d = res_p2_q;
    if (s2_adv) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) res_p2_d = sat_pack(sign_p1_q, zero_p1_q, exp_r, frac_r[6:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      res_p2_q <= res_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_p1_q <= sign_p1_d;
    zero_p1_q <= zero_p1_d;
    mant_p1_q <= mant_p1_d;
    exp_p1_q  <= exp_p1_d;
  end
endmodule

// File: tb/tb_bf16_norm_round.sv
// Directed bench for bf16_norm_round: reset, normalise/round cases, limits,
// backpressure ordering and mid-stream reset.
module tb_bf16_norm_round;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  bf16_norm_round_if #(.MANT_W(12), .EXP_W(10)) bus ();

  bf16_norm_round #(.MANT_W(12), .EXP_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Sends one beat with ready_i high and returns the first result seen (to=1 on timeout).
  task automatic drive_beat(input logic s, input logic signed [9:0] e, input logic [11:0] m,
                            output logic [15:0] r, output bit to);
    int n;
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.sign_i  = s;
    bus.exp_i   = e;
    bus.mant_i  = m;
    bus.valid_i = 1'b1;
    #1;
    n = 0;
    while (!bus.ready_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    n = 0;
    while (!bus.valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    to = !bus.valid_o;
    r  = bus.res_o;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.valid_i = 1'b0;
    bus.sign_i  = 1'b0;
    bus.exp_i   = '0;
    bus.mant_i  = '0;
    bus.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid_o got=%b want=0", bus.valid_o); end
    total++;
    if (bus.res_o !== 16'h0000) begin bad++; $display("FAIL reset_res_o got=%h want=0000", bus.res_o); end
    total++;
    if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_o got=%b want=1", bus.ready_o); end
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    bus.sign_i  = 1'b0;
    bus.exp_i   = 10'sd127;
    bus.mant_i  = 12'h400;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    total++;
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL pass_latency_early got=%b want=0", bus.valid_o); end
    @(negedge clk);
    total++;
    if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL pass_latency_valid got=%b want=1", bus.valid_o); end
    total++;
    if (bus.res_o !== 16'h3F80) begin bad++; $display("FAIL pass_one got=%h want=3F80", bus.res_o); end
  endtask

  task automatic test_carry_lzc();
    logic [15:0] r;
    bit to;
    drive_beat(1'b0, 10'sd127, 12'h800, r, to);
    total++;
    if (to || r !== 16'h4000) begin bad++; $display("FAIL carry got=%h want=4000 timeout=%0d", r, to); end
    drive_beat(1'b0, 10'sd127, 12'h001, r, to);
    total++;
    if (to || r !== 16'h3A80) begin bad++; $display("FAIL lzc10 got=%h want=3A80 timeout=%0d", r, to); end
  endtask

  task automatic test_rounding();
    logic [15:0] r;
    bit to;
    drive_beat(1'b0, 10'sd127, 12'h404, r, to);
    total++;
    if (to || r !== 16'h3F80) begin bad++; $display("FAIL round_tie_even got=%h want=3F80 timeout=%0d", r, to); end
    drive_beat(1'b0, 10'sd127, 12'h40C, r, to);
    total++;
    if (to || r !== 16'h3F82) begin bad++; $display("FAIL round_tie_odd got=%h want=3F82 timeout=%0d", r, to); end
    drive_beat(1'b0, 10'sd127, 12'h7FC, r, to);
    total++;
    if (to || r !== 16'h4000) begin bad++; $display("FAIL round_frac_carry got=%h want=4000 timeout=%0d", r, to); end
  endtask

  task automatic test_limits();
    logic [15:0] r;
    bit to;
    drive_beat(1'b0, 10'sd254, 12'h7FC, r, to);
    total++;
    if (to || r !== 16'h7F80) begin bad++; $display("FAIL overflow_inf got=%h want=7F80 timeout=%0d", r, to); end
    drive_beat(1'b0, 10'sd5, 12'h001, r, to);
    total++;
    if (to || r !== 16'h0000) begin bad++; $display("FAIL underflow_ftz got=%h want=0000 timeout=%0d", r, to); end
    drive_beat(1'b1, 10'sd127, 12'h000, r, to);
    total++;
    if (to || r !== 16'h8000) begin bad++; $display("FAIL signed_zero got=%h want=8000 timeout=%0d", r, to); end
  endtask

  task automatic test_back_to_back();
    logic [15:0]        want [4]  = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};
    logic [11:0]        mants [4] = '{12'h400, 12'h800, 12'h600, 12'h400};
    logic signed [9:0]  exps [4]  = '{10'sd127, 10'sd127, 10'sd128, 10'sd129};
    int          sent = 0;
    int          got  = 0;
    int          stall = 0;
    bit          first_seen = 0;
    bit          saw_block = 0;
    logic [15:0] held = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (bus.valid_o && !first_seen) begin
        first_seen = 1;
        stall      = 3;
        held       = bus.res_o;
      end else if (stall > 0) begin
        total++;
        if (bus.valid_o !== 1'b1 || bus.res_o !== held) begin
          bad++;
          $display("FAIL stall_hold got=%h/%b want=%h/1", bus.res_o, bus.valid_o, held);
        end
      end
      bus.ready_i = (stall > 0) ? 1'b0 : 1'b1;
      if (stall > 0) stall--;
      if (bus.valid_o && bus.ready_i) begin
        total++;
        if (bus.res_o !== want[got]) begin
          bad++;
          $display("FAIL stream_out%0d got=%h want=%h", got, bus.res_o, want[got]);
        end
        got++;
      end
      if (sent < 4) begin
        bus.valid_i = 1'b1;
        bus.sign_i  = 1'b0;
        bus.exp_i   = exps[sent];
        bus.mant_i  = mants[sent];
      end else begin
        bus.valid_i = 1'b0;
      end
      #1;
      if (bus.valid_i && !bus.ready_o) saw_block = 1;
      if (bus.valid_i && bus.ready_o) sent++;
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    total++;
    if (got != 4) begin bad++; $display("FAIL stream_count got=%0d want=4", got); end
    total++;
    if (!saw_block) begin bad++; $display("FAIL ready_o_drop got=%0d want=1", saw_block); end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] r;
    bit to;
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.sign_i = 1'b0; bus.exp_i = 10'sd127; bus.mant_i = 12'h800; bus.valid_i = 1'b1;
    @(negedge clk);
    bus.exp_i = 10'sd128; bus.mant_i = 12'h600;
    @(negedge clk);
    bus.exp_i = 10'sd129; bus.mant_i = 12'h400;
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    bus.valid_i = 1'b0;
    total++;
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid_o got=%b want=0", bus.valid_o); end
    total++;
    if (bus.res_o !== 16'h0000) begin bad++; $display("FAIL midrst_res_o got=%h want=0000", bus.res_o); end
    total++;
    if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL midrst_ready_o got=%b want=1", bus.ready_o); end
    @(negedge clk);
    total++;
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL midrst_s1_flushed got=%b want=0", bus.valid_o); end
    drive_beat(1'b0, 10'sd127, 12'h400, r, to);
    total++;
    if (to || r !== 16'h3F80) begin bad++; $display("FAIL midrst_after got=%h want=3F80 timeout=%0d", r, to); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_carry_lzc();
    test_rounding();
    test_limits();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
